ex_unit: RTL
============

EX_UNIT -- requirements
Module: ex_unit

Interface
REQ-001 SHALL have ports: clk in 1, single clock, all flops on posedge; reset in 1, asynchronous, active-high.
REQ-002 SHALL have ports: ID_to_EX_Valid in 1; EX_Allow_in out 1; ID_to_EX_Bus in 155; ME_Allow_in in 1; EX_to_ME_Valid out 1; EX_to_ME_Bus out 84.
REQ-003 SHALL have ports: data_sram_en out 1; data_sram_we out 4; data_sram_addr out 32; data_sram_wdata out 32.
REQ-004 SHALL have ports: EX_dest out 5, dest masked by valid & gr_we; EX_Forward_Res out 32, result masked by gr_we; ME_to_EX_Sys_op in 1, ME holds exception/ertn; excp_flush in 1; ertn_flush in 1.
REQ-005 ID_to_EX_Bus MSB->LSB SHALL be: excp_en 1, excp_num 7, div_op 2 (00 none, 01 div, 10 mod), div_signed 1, alu_op 4, src1 32, src2 32, rkd_value 32, mem_en 1, mem_we 1, mem_size 2 (00 byte, 01 half, 10 word), mem_signed 1, res_from_mem 1, gr_we 1, dest 5, pc 32.
REQ-006 EX_to_ME_Bus MSB->LSB SHALL be: excp_en 1, excp_num 7, dest_flag 5, pc 32, EX_result 32, res_from_mem 1, gr_we 1, dest 5.

Function
REQ-007 Handshake: EX_Allow_in = !EX_Valid | (EX_ReadyGO & ME_Allow_in); EX_to_ME_Valid = EX_Valid & EX_ReadyGO.
REQ-008 EX_Valid SHALL clear on excp_flush|ertn_flush, else load ID_to_EX_Valid when EX_Allow_in; bus fields latch only when ID_to_EX_Valid & EX_Allow_in.
REQ-009 alu_op: 0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 or, 6 nor, 7 xor, 8 sll, 9 srl, 10 sra (shift amount src2[4:0]), 11 pass src2; 12-15 yield 0.
REQ-010 EX_ReadyGO SHALL be 1 when div_op==00, else 1 only in divider state DONE.
REQ-011 Divider FSM IDLE->BUSY when EX_Valid & div_op!=00 & no excp_en; BUSY runs exactly 32 radix-2 iterations then ->DONE; DONE->IDLE on EX_to_ME_Valid & ME_Allow_in; DONE result held while ME stalls.
REQ-012 Divider latency: handoff no earlier than 34 cycles after latch cycle.
REQ-013 Signed: quotient negative iff operand signs differ; remainder takes dividend sign. Divide-by-zero: quotient 0xFFFFFFFF, remainder = src1, no exception.
REQ-014 EX_result = divider output when div_op!=00, else ALU result.
REQ-015 Memory address = src1 + src2 (32-bit wrap). ALE when mem_en & ((half & addr[0]) | (word & addr[1:0]!=0)): output excp_en=1, excp_num=7'h09, unless incoming excp_en=1, which passes through unchanged and wins.
REQ-016 data_sram_en = EX_to_ME_Valid & ME_Allow_in & mem_en & !out_excp_en & !ME_to_EX_Sys_op & !excp_flush & !ertn_flush; asserted exactly one cycle per instruction.
REQ-017 data_sram_we = mem_we ? (byte 0001<<addr[1:0], half 0011<<{addr[1],0}, word 1111) : 0000, gated by data_sram_en.
REQ-018 data_sram_wdata: byte {4{rkd[7:0]}}, half {2{rkd[15:0]}}, word rkd; data_sram_addr = address, word-aligned not required.
REQ-019 dest_flag = {mem_signed, size==byte, size==half, addr[1:0] (word forces 00)}; non-load SHALL emit 00000.
REQ-020 Flush mid-divide SHALL force FSM to IDLE same edge; next divide starts clean.

Reset
REQ-021 On reset: EX_Valid=0, FSM=IDLE, divider regs 0, latched bus 0; hence EX_to_ME_Valid=0, data_sram_en=0, data_sram_we=0, EX_dest=0, EX_Allow_in=1.
REQ-022 Reset asserted mid-divide SHALL abort immediately, no output valid until a new instruction is latched after deassertion.

Verification
REQ-023 add src1=0x7FFFFFFF src2=1, gr_we=1 dest=5 -> one cycle later EX_to_ME_Valid=1, EX_result=0x80000000, EX_dest=5.
REQ-024 signed div src1=-7 src2=2 -> valid after 34 cycles, result 0xFFFFFFFD; mod -> 0xFFFFFFFF; src2=0 div -> 0xFFFFFFFF.
REQ-025 store byte rkd=0x12345678 addr=0x1003, ME_Allow_in=1 -> data_sram_en=1, we=1000, wdata=0x78787878.
REQ-026 load half signed addr=0x1002 -> dest_flag=10110; addr=0x1001 -> excp_en=1, excp_num=0x09, data_sram_en=0.
REQ-027 ME_Allow_in=0 for 3 cycles holding a completed divide -> EX_result stable, EX_Allow_in=0; excp_flush during BUSY -> EX_Valid=0, FSM IDLE next cycle.

Source files
------------

// File: rtl/ex_unit_if.sv
// Bundle of the ID->EX->ME pipeline handshake, data SRAM request, forwarding and flush
// signals seen by the execute stage.
interface ex_unit_if;
   logic         ID_to_EX_Valid;
   logic         EX_Allow_in;
   logic [154:0] ID_to_EX_Bus;
   logic         ME_Allow_in;
   logic         EX_to_ME_Valid;
   logic [83:0]  EX_to_ME_Bus;
   logic         data_sram_en;
   logic [3:0]   data_sram_we;
   logic [31:0]  data_sram_addr;
   logic [31:0]  data_sram_wdata;
   logic [4:0]   EX_dest;
   logic [31:0]  EX_Forward_Res;
   logic         ME_to_EX_Sys_op;
   logic         excp_flush;
   logic         ertn_flush;

   modport slave (
      input  ID_to_EX_Valid, ID_to_EX_Bus, ME_Allow_in, ME_to_EX_Sys_op, excp_flush, ertn_flush,
      output EX_Allow_in, EX_to_ME_Valid, EX_to_ME_Bus, data_sram_en, data_sram_we,
             data_sram_addr, data_sram_wdata, EX_dest, EX_Forward_Res
   );

   modport master (
      output ID_to_EX_Valid, ID_to_EX_Bus, ME_Allow_in, ME_to_EX_Sys_op, excp_flush, ertn_flush,
      input  EX_Allow_in, EX_to_ME_Valid, EX_to_ME_Bus, data_sram_en, data_sram_we,
             data_sram_addr, data_sram_wdata, EX_dest, EX_Forward_Res
   );
endinterface

// File: rtl/ex_unit.sv
// Execute stage: ALU, 32-iteration radix-2 divider, memory address/ALE generation and
// data SRAM request, with valid/allow-in pipeline handshaking.
module ex_unit (
   input logic    clk,
   input logic    reset,
   ex_unit_if.slave ex
);
   typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

   div_state_t  div_state, div_state_next;
   logic        ex_valid, ex_ready_go, flush, fire_out, div_start, is_div;
   logic        excp_en, div_signed, mem_en, mem_we, mem_signed, res_from_mem, gr_we;
   logic [6:0]  excp_num;
   logic [1:0]  div_op, mem_size;
   logic [3:0]  alu_op;
   logic [31:0] src1, src2, rkd_value, pc;
   logic [4:0]  dest, div_count;
   logic [31:0] quo, rem, src1_abs, src2_abs, div_q, div_r, alu_result, ex_result, mem_addr;
   logic [32:0] div_shift, div_diff;
   logic        ale, out_excp_en, is_load, sram_en;
   logic [6:0]  out_excp_num;
   logic [4:0]  dest_flag;
   logic [3:0]  we_mask;
   logic [31:0] wdata;

   assign flush          = ex.excp_flush | ex.ertn_flush;
   assign is_div         = div_op != 2'b00;
   // An instruction already carrying an exception skips the divider so it cannot wedge the pipe.
   assign ex_ready_go    = !is_div || excp_en || (div_state == DIV_DONE);
   assign ex.EX_Allow_in = !ex_valid || (ex_ready_go && ex.ME_Allow_in);
   assign ex.EX_to_ME_Valid = ex_valid && ex_ready_go;
   assign fire_out       = ex.EX_to_ME_Valid && ex.ME_Allow_in;
   assign div_start      = (div_state == DIV_IDLE) && ex_valid && is_div && !excp_en;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)              ex_valid <= 1'b0;
      else if (flush)         ex_valid <= 1'b0;
      else if (ex.EX_Allow_in) ex_valid <= ex.ID_to_EX_Valid;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         {excp_en, excp_num, div_op, div_signed, alu_op, src1, src2, rkd_value, mem_en, mem_we,
          mem_size, mem_signed, res_from_mem, gr_we, dest, pc} <= '0;
      end else if (ex.ID_to_EX_Valid && ex.EX_Allow_in) begin
         {excp_en, excp_num, div_op, div_signed, alu_op, src1, src2, rkd_value, mem_en, mem_we,
          mem_size, mem_signed, res_from_mem, gr_we, dest, pc} <= ex.ID_to_EX_Bus;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) div_state <= DIV_IDLE;
      else       div_state <= div_state_next;
   end

   always_comb begin
      div_state_next = div_state;
      case (div_state)
         DIV_IDLE: if (div_start) div_state_next = DIV_BUSY;
         DIV_BUSY: if (div_count == 5'd31) div_state_next = DIV_DONE;
         DIV_DONE: if (fire_out) div_state_next = DIV_IDLE;
         default:  div_state_next = DIV_IDLE;
      endcase
      if (flush) div_state_next = DIV_IDLE;
   end

   assign src1_abs  = (div_signed && src1[31]) ? (~src1 + 32'd1) : src1;
   assign src2_abs  = (div_signed && src2[31]) ? (~src2 + 32'd1) : src2;
   assign div_shift = {rem, quo[31]};
   assign div_diff  = div_shift - {1'b0, src2_abs};

   // Restoring division on magnitudes: quo starts as the dividend and fills with quotient bits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         quo       <= '0;
         rem       <= '0;
         div_count <= '0;
      end else if (div_start) begin
         quo       <= src1_abs;
         rem       <= '0;
         div_count <= '0;
      end else if (div_state == DIV_BUSY) begin
         div_count <= div_count + 5'd1;
         if (!div_diff[32]) begin
            rem <= div_diff[31:0];
            quo <= {quo[30:0], 1'b1};
         end else begin
            rem <= div_shift[31:0];
            quo <= {quo[30:0], 1'b0};
         end
      end
   end

   always_comb begin
      div_q = (div_signed && (src1[31] ^ src2[31])) ? (~quo + 32'd1) : quo;
      div_r = (div_signed && src1[31]) ? (~rem + 32'd1) : rem;
      if (src2 == 32'd0) begin
         div_q = 32'hFFFF_FFFF;
         div_r = src1;
      end
   end

   always_comb begin
      alu_result = '0;
      case (alu_op)
         4'd0:  alu_result = src1 + src2;
         4'd1:  alu_result = src1 - src2;
         4'd2:  alu_result = {31'd0, $signed(src1) < $signed(src2)};
         4'd3:  alu_result = {31'd0, src1 < src2};
         4'd4:  alu_result = src1 & src2;
         4'd5:  alu_result = src1 | src2;
         4'd6:  alu_result = ~(src1 | src2);
         4'd7:  alu_result = src1 ^ src2;
         4'd8:  alu_result = src1 << src2[4:0];
         4'd9:  alu_result = src1 >> src2[4:0];
         4'd10: alu_result = $unsigned($signed(src1) >>> src2[4:0]);
         4'd11: alu_result = src2;
         default: alu_result = '0;
      endcase
   end

   assign ex_result = is_div ? (div_op[1] ? div_r : div_q) : alu_result;

   assign mem_addr     = src1 + src2;
   assign ale          = mem_en && (((mem_size == 2'b01) && mem_addr[0]) ||
                                    ((mem_size == 2'b10) && (mem_addr[1:0] != 2'b00)));
   assign out_excp_en  = excp_en || ale;
   assign out_excp_num = (!excp_en && ale) ? 7'h09 : excp_num;
   assign is_load      = mem_en && !mem_we;
   assign dest_flag    = is_load ? {mem_signed, mem_size == 2'b00, mem_size == 2'b01,
                                    (mem_size == 2'b10) ? 2'b00 : mem_addr[1:0]} : 5'd0;
   assign sram_en      = fire_out && mem_en && !out_excp_en && !ex.ME_to_EX_Sys_op && !flush;

   always_comb begin
      we_mask = 4'b1111;
      wdata   = rkd_value;
      case (mem_size)
         2'b00: begin
            we_mask = 4'b0001 << mem_addr[1:0];
            wdata   = {4{rkd_value[7:0]}};
         end
         2'b01: begin
            we_mask = mem_addr[1] ? 4'b1100 : 4'b0011;
            wdata   = {2{rkd_value[15:0]}};
         end
         default: begin
            we_mask = 4'b1111;
            wdata   = rkd_value;
         end
      endcase
   end

   assign ex.data_sram_en    = sram_en;
   assign ex.data_sram_we    = (sram_en && mem_we) ? we_mask : 4'b0000;
   assign ex.data_sram_addr  = mem_addr;
   assign ex.data_sram_wdata = wdata;
   assign ex.EX_dest         = (ex_valid && gr_we) ? dest : 5'd0;
   assign ex.EX_Forward_Res  = gr_we ? ex_result : 32'd0;
   assign ex.EX_to_ME_Bus    = {out_excp_en, out_excp_num, dest_flag, pc, ex_result,
                                res_from_mem, gr_we, dest};
endmodule
